// File: rtl/imul_seq_if.sv
// imul_seq start/ready/done handshake bundle.
// The master drives the request and the slave returns the product.
interface imul_seq_if #(
    parameter int SIZE = 16
);
    logic              iStart;
    logic              iSigned;
    logic [SIZE-1:0]   iA;
    logic [SIZE-1:0]   iB;
    logic              oReady;
    logic              oDone;
    logic [2*SIZE-1:0] oProduct;

    modport master (
        output iStart, iSigned, iA, iB,
        input  oReady, oDone, oProduct
    );

    modport slave (
        input  iStart, iSigned, iA, iB,
        output oReady, oDone, oProduct
    );
endinterface

// File: rtl/imul_seq.sv
// Iterative signed/unsigned multiplier.
// It retires BITS_PER_CYCLE multiplier bits per clock.
module imul_seq #(
    parameter int SIZE           = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic       Clock,
    input logic       Reset,
    imul_seq_if.slave bus
);
    localparam int N  = SIZE / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = 2 * SIZE;

    if (!(BITS_PER_CYCLE inside {1, 2, 4, 8}) ||
        (SIZE % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("imul_seq: illegal SIZE/BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                    state;
    logic [SIZE-1:0]           mag_a;
    logic [SIZE-1:0]           mr;
    logic                      neg;
    logic [W-1:0]              acc;
    logic [W-1:0]              prod_q;
    logic                      done_q;
    logic [CW-1:0]             cnt;

    logic [SIZE-1:0]           abs_a;
    logic [SIZE-1:0]           abs_b;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [W-1:0]              pp;

    always_comb begin
        abs_a = bus.iA;
        abs_b = bus.iB;
        if (bus.iSigned && bus.iA[SIZE-1])
            abs_a = ~bus.iA + SIZE'(1);
        if (bus.iSigned && bus.iB[SIZE-1])
            abs_b = ~bus.iB + SIZE'(1);
        digit = mr[BITS_PER_CYCLE-1:0];
        pp    = W'(mag_a) * W'(digit);
    end

    always_ff @(posedge Clock) begin
        done_q <= 1'b0;
        if (Reset) begin
            state  <= IDLE;
            mag_a  <= '0;
            mr     <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            prod_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        mag_a <= abs_a;
                        mr    <= abs_b;
                        neg   <= bus.iSigned &
                                 (bus.iA[SIZE-1] ^ bus.iB[SIZE-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // partial product lands at weight k*BITS_PER_CYCLE
                    acc <= acc + (pp << (int'(cnt) * BITS_PER_CYCLE));
                    mr  <= mr >> BITS_PER_CYCLE;
                    if (cnt == CW'(N - 1))
                        state <= DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                DONE: begin
                    prod_q <= neg ? (~acc + W'(1)) : acc;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady   = (state == IDLE);
    assign bus.oDone    = done_q;
    assign bus.oProduct = prod_q;
endmodule
